// File: rtl/seq_pipe_add3_collect_if.sv
// Handshake bundle for the three-operand collector: a serial operand stream
// in (val/rdy + last) and a registered operand triple out (val/rdy + count).
// master = the side that feeds operands and consumes groups; slave = collector.
interface seq_pipe_add3_collect_if #(
    parameter int NBITS = 8
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_msg;
    logic             in_last;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out0;
    logic [NBITS-1:0] out1;
    logic [NBITS-1:0] out2;
    logic [1:0]       out_count;

    modport master (
        output in_val, in_msg, in_last, out_rdy,
        input  in_rdy, out_val, out0, out1, out2, out_count
    );

    modport slave (
        input  in_val, in_msg, in_last, out_rdy,
        output in_rdy, out_val, out0, out1, out2, out_count
    );
endinterface

// File: rtl/seq_pipe_add3_collect.sv
// Operand collector for the three-input adder pipeline. Packs a serial
// operand stream into triples; in_last closes a group early and the missing
// operands are zero so the downstream sum is unaffected. The output triple is
// registered and is replaced in the same cycle it drains, so back-to-back
// groups sustain one operand per cycle.
module seq_pipe_add3_collect #(
    parameter int NBITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_pipe_add3_collect_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HAVE1 = 2'd1,
        HAVE2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] op0_q, op0_d;
    logic [NBITS-1:0] op1_q, op1_d;
    logic [NBITS-1:0] out0_q, out0_d;
    logic [NBITS-1:0] out1_q, out1_d;
    logic [NBITS-1:0] out2_q, out2_d;
    logic [1:0]       count_q, count_d;
    logic             val_q, val_d;

    logic in_fire;
    logic out_fire;
    logic launch;

    // Ready depends only on the output slot and out_rdy, never on in_val.
    assign bus.in_rdy    = !val_q || bus.out_rdy;
    assign in_fire       = bus.in_val && bus.in_rdy;
    assign out_fire      = val_q && bus.out_rdy;

    assign bus.out_val   = val_q;
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.out2      = out2_q;
    assign bus.out_count = count_q;

    // Next-state: stage operands and launch a finished group into the output slot.
    always_comb begin
        // NOTE: every signal driven here gets a hold/default value first, so no
        // path through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        count_d = count_q;
        launch  = 1'b0;

        if (in_fire) begin
            case (state_q)
                IDLE: begin
                    op0_d = bus.in_msg;
                    if (bus.in_last) begin
                        launch  = 1'b1;
                        out0_d  = bus.in_msg;
                        out1_d  = '0;
                        out2_d  = '0;
                        count_d = 2'd1;
                    end else begin
                        state_d = HAVE1;
                    end
                end
                HAVE1: begin
                    op1_d = bus.in_msg;
                    if (bus.in_last) begin
                        launch  = 1'b1;
                        out0_d  = op0_q;
                        out1_d  = bus.in_msg;
                        out2_d  = '0;
                        count_d = 2'd2;
                        state_d = IDLE;
                    end else begin
                        state_d = HAVE2;
                    end
                end
                HAVE2: begin
                    // Third operand always closes the group; in_last is irrelevant.
                    launch  = 1'b1;
                    out0_d  = op0_q;
                    out1_d  = op1_q;
                    out2_d  = bus.in_msg;
                    count_d = 2'd3;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // A launch wins over a drain so the slot stays full when both happen.
        val_d = val_q;
        if (launch) begin
            val_d = 1'b1;
        end else if (out_fire) begin
            val_d = 1'b0;
        end
    end

    // State, staging and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q <= IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            count_q <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            count_q <= count_d;
            val_q   <= val_d;
        end
    end

endmodule

// File: tb/tb_seq_pipe_add3_collect.sv
// Self-checking bench for seq_pipe_add3_collect: directed scenarios with
// explicit expected groups, then a randomized stream, all compared every
// cycle against a queue-based reference model of the grouping rules.
module tb_seq_pipe_add3_collect;

    localparam int NBITS = 8;

    logic clk;
    logic reset;

    seq_pipe_add3_collect_if #(.NBITS(NBITS)) bus ();

    seq_pipe_add3_collect #(.NBITS(NBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    // Reference model: pending operands of the open group, and the output slot.
    logic [NBITS-1:0] pend[$];
    logic             m_val;
    logic [NBITS-1:0] m_out[3];
    logic [1:0]       m_cnt;
    int               m_groups;
    int               skip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model
    // with the inputs that were presented during that cycle.
    task automatic tick();
        logic fire_in;
        logic fire_out;
        logic launch;
        logic [NBITS-1:0] g[3];
        int n;
        @(negedge clk);
        if (skip > 0) begin
            skip--;
        end else begin
            check("in_rdy", bus.in_rdy, !m_val || bus.out_rdy);
            check("out_val", bus.out_val, m_val);
            if (m_val) begin
                check("out0", bus.out0, m_out[0]);
                check("out1", bus.out1, m_out[1]);
                check("out2", bus.out2, m_out[2]);
                check("out_count", bus.out_count, m_cnt);
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
            m_val = 1'b0;
            m_out = '{default: '0};
            m_cnt = 2'd0;
        end else begin
            fire_in  = bus.in_val && (!m_val || bus.out_rdy);
            fire_out = m_val && bus.out_rdy;
            launch   = 1'b0;
            if (fire_in) begin
                pend.push_back(bus.in_msg);
                if (bus.in_last || pend.size() == 3) begin
                    n = pend.size();
                    for (int i = 0; i < 3; i++) g[i] = (i < n) ? pend[i] : '0;
                    pend.delete();
                    launch = 1'b1;
                    m_out  = g;
                    m_cnt  = 2'(n);
                    m_groups++;
                end
            end
            if (launch) m_val = 1'b1;
            else if (fire_out) m_val = 1'b0;
        end
    endtask

    task automatic drv(input logic v, input logic [NBITS-1:0] m, input logic l);
        bus.in_val  = v;
        bus.in_msg  = m;
        bus.in_last = l;
        tick();
    endtask

    task automatic expect_grp(input string tag, input logic [NBITS-1:0] a,
                              input logic [NBITS-1:0] b, input logic [NBITS-1:0] c,
                              input logic [1:0] n);
        check({tag, "_val"}, bus.out_val, 1'b1);
        check({tag, "_out0"}, bus.out0, a);
        check({tag, "_out1"}, bus.out1, b);
        check({tag, "_out2"}, bus.out2, c);
        check({tag, "_count"}, bus.out_count, n);
    endtask

    initial begin
        int drops;
        int cycles;
        logic [NBITS-1:0] stream[6];
        stream = '{8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};

        m_val = 1'b0;
        m_out = '{default: '0};
        m_cnt = 2'd0;
        m_groups = 0;
        skip = 0;
        reset = 1'b1;
        bus.in_val = 1'b0;
        bus.in_msg = '0;
        bus.in_last = 1'b0;
        bus.out_rdy = 1'b1;

        // Reset state.
        skip = 1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_val", bus.out_val, 1'b0);
        check("rst_out0", bus.out0, 8'h00);
        check("rst_count", bus.out_count, 2'd0);
        check("rst_in_rdy", bus.in_rdy, 1'b1);

        // Full triple, then the slot empties.
        drv(1, 8'h01, 0);
        drv(1, 8'h02, 0);
        drv(1, 8'h04, 1);
        expect_grp("t1", 8'h01, 8'h02, 8'h04, 2'd3);
        drv(0, 8'h00, 0);
        check("t1_clear", bus.out_val, 1'b0);

        // Short groups closed by in_last.
        drv(1, 8'h2a, 1);
        expect_grp("t2a", 8'h2a, 8'h00, 8'h00, 2'd1);
        drv(1, 8'h0d, 0);
        drv(1, 8'h2a, 1);
        expect_grp("t2b", 8'h0d, 8'h2a, 8'h00, 2'd2);
        drv(0, 8'h00, 0);

        // Backpressure: group held, next operand waits, then drain + accept together.
        bus.out_rdy = 1'b0;
        drv(1, 8'h01, 0);
        drv(1, 8'h01, 0);
        drv(1, 8'h01, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'h05, 0);
            check("t3_stall_rdy", bus.in_rdy, 1'b0);
            expect_grp("t3_hold", 8'h01, 8'h01, 8'h01, 2'd3);
        end
        bus.out_rdy = 1'b1;
        #1;
        check("t3_release_rdy", bus.in_rdy, 1'b1);
        drv(1, 8'h05, 0);
        check("t3_drain", bus.out_val, 1'b0);
        drv(1, 8'h06, 0);
        drv(1, 8'h07, 1);
        expect_grp("t3_next", 8'h05, 8'h06, 8'h07, 2'd3);
        drv(0, 8'h00, 0);

        // Full-rate stream: in_rdy never drops.
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.in_rdy) drops++;
            drv(1, stream[i], 0);
            if (i == 2) expect_grp("t4_g1", 8'h03, 8'h02, 8'h01, 2'd3);
            if (i == 5) expect_grp("t4_g2", 8'h02, 8'h01, 8'h02, 2'd3);
        end
        check("t4_rdy_drops", drops, 0);
        drv(0, 8'h00, 0);

        // Reset mid-group discards partial operands.
        drv(1, 8'h07, 0);
        drv(1, 8'h08, 0);
        reset = 1'b1;
        drv(0, 8'h00, 0);
        reset = 1'b0;
        check("t5_rst_val", bus.out_val, 1'b0);
        drv(1, 8'h01, 0);
        drv(1, 8'h02, 0);
        drv(1, 8'h03, 1);
        expect_grp("t5", 8'h01, 8'h02, 8'h03, 2'd3);

        // High-bit patterns pass through unchanged.
        drv(1, 8'hff, 0);
        drv(1, 8'h80, 0);
        drv(1, 8'h7f, 0);
        expect_grp("t6", 8'hff, 8'h80, 8'h7f, 2'd3);
        drv(0, 8'h00, 0);

        // Randomized stream of 20 groups after a fresh reset.
        reset = 1'b1;
        drv(0, 8'h00, 0);
        reset = 1'b0;
        skip = 2;
        m_groups = 0;
        cycles = 0;
        while (m_groups < 20 && cycles < 2000) begin
            bus.out_rdy = ($urandom_range(0, 9) < 7);
            drv(($urandom_range(0, 3) != 0), NBITS'($urandom),
                ($urandom_range(0, 2) == 0));
            cycles++;
        end
        check("rnd_groups_done", (m_groups >= 20), 1'b1);
        bus.out_rdy = 1'b1;
        drv(0, 8'h00, 0);
        drv(0, 8'h00, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
